reg_file_mp: RTL and testbench

Parametrised multi-port register file: two combinational read ports, two synchronous write ports with a fixed priority, optional write-to-read bypass, optional hardwired zero register, and a background clear sequencer that zeroes the array one entry per cycle. It is the datapath register file for the CPU lab cores. It replaces the fixed 16×4 single-write file.

---
 rtl/reg_file_mp.sv | 105 ++++++++++
 tb/tb_reg_file_mp.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: two combinational read ports, two prioritised write
// ports, optional write-to-read bypass and zero register, plus a background clear sequencer.
module reg_file_mp #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    wa0,
  input  logic [AW-1:0]    wa1,
  input  logic [WIDTH-1:0] wd0,
  input  logic [WIDTH-1:0] wd1,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_e;

  state_e           state_q;
  logic [AW-1:0]    ptr_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Later assignments win: port 1 over port 0 over the clear; zero register over all.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (state_q == S_CLEAR && ptr_q == AW'(i)) mem_d[i] = '0;
      if (we0 && wa0 == AW'(i)) mem_d[i] = wd0;
      if (we1 && wa1 == AW'(i)) mem_d[i] = wd1;
      if (ZERO_REG && i == 0) mem_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Bypass reads the next-state array, which already folds in write and clear hits.
  always_comb begin
    rd0 = '0;
    rd1 = '0;
    if (rst_n) begin
      rd0 = BYPASS ? mem_d[ra0] : mem_q[ra0];
      rd1 = BYPASS ? mem_d[ra1] : mem_q[ra1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (clr_req) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = busy_q;
  assign clr_done = done_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp; a BYPASS=0 copy shares all inputs.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra0, ra1, wa0, wa1;
  logic        we0, we1, clr_req;
  logic [31:0] wd0, wd1;
  logic [31:0] rd0, rd1, nb_rd0, nb_rd1;
  logic        busy, done, nb_busy, nb_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .clr_req(clr_req), .clr_busy(busy), .clr_done(done)
  );

  reg_file_mp #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .ra0(ra0), .ra1(ra1), .rd0(nb_rd0), .rd1(nb_rd1),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .clr_req(clr_req), .clr_busy(nb_busy), .clr_done(nb_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check_eq(tag, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    bit seen;
    // Reset with arbitrary active inputs
    rst_n = 1'b0; clr_req = 1'b1;
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hFFFF_0000;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h1357_9BDF;
    ra0 = 5'd3; ra1 = 5'd9;
    #12;
    check_eq("rst_rd0", rd0, 32'h0);
    check_eq("rst_rd1", rd1, 32'h0);
    check_eq("rst_busy", {31'b0, busy}, 32'h0);
    check_eq("rst_done", {31'b0, done}, 32'h0);
    we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i); ra1 = 5'(31 - i); #1;
      check_eq("post_rst_rd0", rd0, 32'h0);
      check_eq("post_rst_rd1", rd1, 32'h0);
    end

    // Basic write/read and zero register
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
    tick(); we0 = 1'b0;
    ra0 = 5'd5; #1;
    check_eq("wr_rd_5", rd0, 32'hDEAD_BEEF);
    check_eq("wr_rd_5_nb", nb_rd0, 32'hDEAD_BEEF);
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h1234; ra1 = 5'd0; #1;
    check_eq("zero_bypass", rd1, 32'h0);
    tick(); we1 = 1'b0; #1;
    check_eq("zero_stored", rd1, 32'h0);
    check_eq("zero_stored_nb", nb_rd1, 32'h0);

    // Collision, port 1 wins; bypass vs. no bypass
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1111_1111;
    tick(); we0 = 1'b0;
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA_0000;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h5555_FFFF;
    ra0 = 5'd7; #1;
    check_eq("coll_bypass", rd0, 32'h5555_FFFF);
    check_eq("coll_nobypass", nb_rd0, 32'h1111_1111);
    tick(); we0 = 1'b0; we1 = 1'b0; #1;
    check_eq("coll_stored", rd0, 32'h5555_FFFF);
    check_eq("coll_stored_nb", nb_rd0, 32'h5555_FFFF);
    // Port 0 alone bypasses when port 1 targets elsewhere
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA_0000;
    we1 = 1'b1; wa1 = 5'd8; wd1 = 32'h0BAD_F00D; #1;
    check_eq("p0_bypass", rd0, 32'hAAAA_0000);
    tick(); we0 = 1'b0; we1 = 1'b0;

    // Full clear with clr_req held high
    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1; wa0 = 5'(i); wd0 = 32'(i + 1);
      tick();
    end
    we0 = 1'b0;
    clr_req = 1'b1;
    tick();
    check_eq("clr_busy_start", {31'b0, busy}, 32'd1);
    check_eq("clr_done_start", {31'b0, done}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      ra0 = 5'(k); ra1 = (k < 31) ? 5'(k + 1) : 5'd0; #1;
      check_eq("clr_hit_bypass", rd0, 32'h0);
      check_eq("clr_hit_nobypass", nb_rd0, (k == 0) ? 32'h0 : 32'(k + 1));
      tick();
      check_eq("clr_entry_zero", nb_rd0, 32'h0);
      if (k < 31) check_eq("clr_next_kept", nb_rd1, 32'(k + 2));
      check_eq("clr_busy", {31'b0, busy}, (k < 31) ? 32'd1 : 32'd0);
      check_eq("clr_done", {31'b0, done}, (k == 31) ? 32'd1 : 32'd0);
    end
    tick();
    check_eq("clr_done_pulse_end", {31'b0, done}, 32'd0);
    check_eq("clr_no_restart_in_done", {31'b0, busy}, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 3 && !seen; c++) begin
      if (busy) seen = 1'b1;
      else tick();
    end
    check_eq("clr_restart_after_idle", {31'b0, seen}, 32'd1);
    clr_req = 1'b0;
    wait_done("clr_restart_done");
    tick();

    // Writes during clear
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int j = 1; j <= 33; j++) begin
      we0 = (j == 5) || (j == 11);
      wa0 = (j == 5) ? 5'd20 : 5'd10;
      wd0 = (j == 5) ? 32'h99 : 32'h77;
      tick();
      we0 = 1'b0;
      if (j == 5) begin
        ra1 = 5'd20; #1;
        check_eq("wdc_20_before", nb_rd1, 32'h99);
      end
    end
    ra0 = 5'd10; ra1 = 5'd20; #1;
    check_eq("wdc_10_kept", nb_rd0, 32'h77);
    check_eq("wdc_20_cleared", nb_rd1, 32'h0);
    check_eq("wdc_idle", {31'b0, busy}, 32'd0);

    // Reset in the middle of a clear
    we0 = 1'b1; wa0 = 5'd31; wd0 = 32'hABCD;
    tick(); we0 = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int j = 1; j <= 7; j++) tick();
    ra0 = 5'd31; ra1 = 5'd10; #1;
    check_eq("mid_pre_rst_31", nb_rd0, 32'hABCD);
    rst_n = 1'b0; #1;
    check_eq("mid_rst_31", nb_rd0, 32'h0);
    check_eq("mid_rst_busy", {31'b0, busy}, 32'd0);
    check_eq("mid_rst_done", {31'b0, done}, 32'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      check_eq("mid_rst_no_done", {31'b0, done}, 32'd0);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    check_eq("mid_post_rst_31", nb_rd0, 32'h0);
    check_eq("mid_post_rst_done", {31'b0, done}, 32'd0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check_eq("mid_new_clear", {31'b0, busy}, 32'd1);
    wait_done("mid_new_clear_done");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
